// File: rtl/spi_pkg.sv
// Shared definitions for the SPI frame sequencer: FSM state encoding and
// default widths used by spi_frame_ctrl and its FIFOs.
package spi_pkg;

  localparam int CHAR_NBITS_DEF  = 16;
  localparam int FIFO_DEPTH_DEF  = 8;
  localparam int LEN_WIDTH_DEF   = 8;
  localparam int CSDLY_WIDTH_DEF = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_ARM   = 3'd2,
    ST_XFER  = 3'd3,
    ST_HOLD  = 3'd4
  } frame_state_t;

endpackage

// File: rtl/spi_sync_fifo.sv
// Synchronous first-word-fall-through FIFO. Pointers carry one extra wrap
// bit so full and empty can be told apart when the index bits match.
// A write into a full FIFO is accepted only when a read frees a slot in
// the same cycle, so occupancy stays unchanged.
module spi_sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             full,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             wr_ok;
  logic             rd_ok;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_ok   = rd_en && !empty;
  assign wr_ok   = wr_en && (!full || rd_ok);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  // Advance read/write pointers; reset flushes the FIFO.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage array, written on accepted pushes only.
  always_ff @(posedge clock) begin
    if (wr_ok) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/spi_frame_ctrl.sv
// Frame sequencer in front of the single-char SPI engine. Turns one frame
// request into N back-to-back chars, feeding TX chars from a FIFO and
// storing echoed chars in an RX FIFO while holding chip select low.
// Optional feature macro: SPI_FRAME_CSDLY_EN enables programmable CS
// setup/hold delays. A delay value N keeps the FSM in SETUP (or HOLD) for
// max(N,1) cycles; without the macro each of those states lasts 1 cycle.
module spi_frame_ctrl
  import spi_pkg::*;
#(
  parameter int CHAR_NBITS  = CHAR_NBITS_DEF,
  parameter int FIFO_DEPTH  = FIFO_DEPTH_DEF,
  parameter int LEN_WIDTH   = LEN_WIDTH_DEF,
  parameter int CSDLY_WIDTH = CSDLY_WIDTH_DEF
) (
  input  logic                   S_SYSCLK,
  input  logic                   S_RESET,
  input  logic                   S_ENABLE,
  input  logic                   S_FRAME_GO,
  input  logic [LEN_WIDTH-1:0]   S_FRAME_LEN,
  input  logic [CSDLY_WIDTH-1:0] S_CS_SETUP,
  input  logic [CSDLY_WIDTH-1:0] S_CS_HOLD,
  input  logic                   S_TX_WR,
  input  logic [CHAR_NBITS-1:0]  S_TX_DATA,
  output logic                   S_TX_FULL,
  input  logic                   S_RX_RD,
  output logic [CHAR_NBITS-1:0]  S_RX_DATA,
  output logic                   S_RX_EMPTY,
  output logic                   S_BUSY,
  output logic                   S_FRAME_DONE,
  output logic                   S_ABORT,
  output logic                   S_SPI_CS_N,
  output logic                   M_CHAR_GO,
  input  logic                   M_CHAR_DONE,
  output logic [CHAR_NBITS-1:0]  M_WCHAR,
  input  logic [CHAR_NBITS-1:0]  M_RCHAR
);

  frame_state_t           state, state_next;
  logic [LEN_WIDTH-1:0]   remaining, remaining_next;
  logic [CSDLY_WIDTH-1:0] dly_cnt, dly_next;
  logic                   cs_n, cs_n_next;
  logic                   go, go_next;
  logic [CHAR_NBITS-1:0]  wchar, wchar_next;
  logic                   frame_done, frame_done_next;
  logic                   abort, abort_next;

  logic                   tx_pop;
  logic                   rx_push;
  logic                   tx_empty;
  logic                   rx_full;
  logic [CHAR_NBITS-1:0]  tx_head;
  logic [CSDLY_WIDTH-1:0] setup_load;
  logic [CSDLY_WIDTH-1:0] hold_load;

`ifdef SPI_FRAME_CSDLY_EN
  assign setup_load = S_CS_SETUP;
  assign hold_load  = S_CS_HOLD;
`else
  logic unused_csdly;
  assign unused_csdly = ^{S_CS_SETUP, S_CS_HOLD};
  assign setup_load   = '0;
  assign hold_load    = '0;
`endif

  spi_sync_fifo #(.WIDTH(CHAR_NBITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clock   (S_SYSCLK),
    .reset   (S_RESET),
    .wr_en   (S_TX_WR),
    .wr_data (S_TX_DATA),
    .full    (S_TX_FULL),
    .rd_en   (tx_pop),
    .rd_data (tx_head),
    .empty   (tx_empty)
  );

  spi_sync_fifo #(.WIDTH(CHAR_NBITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clock   (S_SYSCLK),
    .reset   (S_RESET),
    .wr_en   (rx_push),
    .wr_data (M_RCHAR),
    .full    (rx_full),
    .rd_en   (S_RX_RD),
    .rd_data (S_RX_DATA),
    .empty   (S_RX_EMPTY)
  );

  // State register plus all registered outputs and counters.
  always_ff @(posedge S_SYSCLK) begin
    if (S_RESET) begin
      state      <= ST_IDLE;
      remaining  <= '0;
      dly_cnt    <= '0;
      cs_n       <= 1'b1;
      go         <= 1'b0;
      wchar      <= '0;
      frame_done <= 1'b0;
      abort      <= 1'b0;
    end else begin
      state      <= state_next;
      remaining  <= remaining_next;
      dly_cnt    <= dly_next;
      cs_n       <= cs_n_next;
      go         <= go_next;
      wchar      <= wchar_next;
      frame_done <= frame_done_next;
      abort      <= abort_next;
    end
  end

  // Next-state logic; dropping S_ENABLE outside IDLE overrides everything.
  always_comb begin
    state_next      = state;
    remaining_next  = remaining;
    dly_next        = dly_cnt;
    cs_n_next       = cs_n;
    go_next         = go;
    wchar_next      = wchar;
    frame_done_next = 1'b0;
    abort_next      = abort;
    tx_pop          = 1'b0;
    rx_push         = 1'b0;

    if (state != ST_IDLE && !S_ENABLE) begin
      state_next = ST_IDLE;
      go_next    = 1'b0;
      cs_n_next  = 1'b1;
      abort_next = 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (S_FRAME_GO && S_ENABLE) begin
            abort_next = 1'b0;
            if (S_FRAME_LEN != '0) begin
              remaining_next = S_FRAME_LEN;
              dly_next       = setup_load;
              cs_n_next      = 1'b0;
              state_next     = ST_SETUP;
            end else begin
              frame_done_next = 1'b1;
            end
          end
        end
        ST_SETUP: begin
          if (dly_cnt <= CSDLY_WIDTH'(1)) state_next = ST_ARM;
          else                            dly_next   = dly_cnt - 1'b1;
        end
        ST_ARM: begin
          if (!tx_empty && !rx_full) begin
            tx_pop     = 1'b1;
            wchar_next = tx_head;
            go_next    = 1'b1;
            state_next = ST_XFER;
          end
        end
        ST_XFER: begin
          if (M_CHAR_DONE) begin
            rx_push        = 1'b1;
            go_next        = 1'b0;
            remaining_next = remaining - 1'b1;
            if (remaining == LEN_WIDTH'(1)) begin
              dly_next   = hold_load;
              state_next = ST_HOLD;
            end else begin
              state_next = ST_ARM;
            end
          end
        end
        ST_HOLD: begin
          if (dly_cnt <= CSDLY_WIDTH'(1)) begin
            cs_n_next       = 1'b1;
            frame_done_next = 1'b1;
            state_next      = ST_IDLE;
          end else begin
            dly_next = dly_cnt - 1'b1;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  assign S_BUSY       = (state != ST_IDLE);
  assign S_FRAME_DONE = frame_done;
  assign S_ABORT      = abort;
  assign S_SPI_CS_N   = cs_n;
  assign M_CHAR_GO    = go;
  assign M_WCHAR      = wchar;

endmodule

// File: tb/tb_spi_frame_ctrl.sv
// Self-checking bench for spi_frame_ctrl. A small behavioural char engine
// answers each M_CHAR_GO after a few cycles with M_WCHAR ^ 16'hA500.
// Honours SPI_FRAME_CSDLY_EN when choosing the expected CS delays.
module tb_spi_frame_ctrl;

  localparam int CW  = 16;
  localparam int LW  = 8;
  localparam int DW  = 4;
  localparam int LAT = 4;

`ifdef SPI_FRAME_CSDLY_EN
  // SETUP lasts 5 cycles, plus the ARM cycle that pops the first char.
  localparam int EXP_SETUP = 6;
  localparam int EXP_HOLD  = 3;
`else
  // SETUP lasts 1 cycle, plus the ARM cycle that pops the first char.
  localparam int EXP_SETUP = 2;
  localparam int EXP_HOLD  = 1;
`endif

  logic          clk = 1'b0;
  logic          S_RESET, S_ENABLE, S_FRAME_GO, S_TX_WR, S_RX_RD;
  logic [LW-1:0] S_FRAME_LEN;
  logic [DW-1:0] S_CS_SETUP, S_CS_HOLD;
  logic [CW-1:0] S_TX_DATA, S_RX_DATA, M_WCHAR, M_RCHAR;
  logic          S_TX_FULL, S_RX_EMPTY, S_BUSY, S_FRAME_DONE, S_ABORT, S_SPI_CS_N;
  logic          M_CHAR_GO, M_CHAR_DONE;

  int errors = 0;
  int checks = 0;

  spi_frame_ctrl dut (
    .S_SYSCLK(clk), .S_RESET(S_RESET), .S_ENABLE(S_ENABLE), .S_FRAME_GO(S_FRAME_GO),
    .S_FRAME_LEN(S_FRAME_LEN), .S_CS_SETUP(S_CS_SETUP), .S_CS_HOLD(S_CS_HOLD),
    .S_TX_WR(S_TX_WR), .S_TX_DATA(S_TX_DATA), .S_TX_FULL(S_TX_FULL),
    .S_RX_RD(S_RX_RD), .S_RX_DATA(S_RX_DATA), .S_RX_EMPTY(S_RX_EMPTY),
    .S_BUSY(S_BUSY), .S_FRAME_DONE(S_FRAME_DONE), .S_ABORT(S_ABORT),
    .S_SPI_CS_N(S_SPI_CS_N), .M_CHAR_GO(M_CHAR_GO), .M_CHAR_DONE(M_CHAR_DONE),
    .M_WCHAR(M_WCHAR), .M_RCHAR(M_RCHAR)
  );

  always #5 clk = ~clk;

  // Behavioural char engine: one DONE pulse LAT cycles after GO is seen.
  int   eng_cnt;
  logic eng_busy;
  always @(posedge clk) begin
    if (S_RESET) begin
      M_CHAR_DONE <= 1'b0;
      M_RCHAR     <= '0;
      eng_busy    <= 1'b0;
      eng_cnt     <= 0;
    end else begin
      M_CHAR_DONE <= 1'b0;
      if (!eng_busy) begin
        if (M_CHAR_GO && !M_CHAR_DONE) begin
          eng_busy <= 1'b1;
          eng_cnt  <= LAT;
        end
      end else if (!M_CHAR_GO) begin
        eng_busy <= 1'b0;
      end else if (eng_cnt == 1) begin
        M_CHAR_DONE <= 1'b1;
        M_RCHAR     <= M_WCHAR ^ 16'hA500;
        eng_busy    <= 1'b0;
      end else begin
        eng_cnt <= eng_cnt - 1;
      end
    end
  end

  // Event counters sampled on the falling edge.
  int   go_rises = 0;
  int   done_cycles = 0;
  int   cs_viol = 0;
  logic go_prev = 1'b0;
  always @(negedge clk) begin
    if (M_CHAR_GO && !go_prev) go_rises++;
    if (S_FRAME_DONE) done_cycles++;
    if (M_CHAR_GO && S_SPI_CS_N) cs_viol++;
    go_prev = M_CHAR_GO;
  end

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic push_tx(input logic [CW-1:0] d);
    S_TX_WR = 1'b1; S_TX_DATA = d;
    tick(1);
    S_TX_WR = 1'b0;
  endtask

  task automatic pop_rx();
    S_RX_RD = 1'b1;
    tick(1);
    S_RX_RD = 1'b0;
  endtask

  task automatic start_frame(input logic [LW-1:0] len);
    S_FRAME_LEN = len; S_FRAME_GO = 1'b1;
    tick(1);
    S_FRAME_GO = 1'b0;
  endtask

  task automatic wait_idle(output bit timed_out);
    int budget = 500;
    while (S_BUSY && budget > 0) begin
      tick(1);
      budget--;
    end
    timed_out = S_BUSY;
  endtask

  task automatic test_reset();
    S_RESET = 1'b1;
    tick(3);
    checks++; if (S_SPI_CS_N !== 1'b1) begin errors++; $display("[TB] FAIL reset_cs_n: got %b, expected 1", S_SPI_CS_N); end
    checks++; if (M_CHAR_GO !== 1'b0) begin errors++; $display("[TB] FAIL reset_go: got %b, expected 0", M_CHAR_GO); end
    checks++; if (M_WCHAR !== 16'h0000) begin errors++; $display("[TB] FAIL reset_wchar: got %h, expected 0000", M_WCHAR); end
    checks++; if ({S_BUSY, S_FRAME_DONE, S_ABORT} !== 3'b000) begin errors++; $display("[TB] FAIL reset_status: got busy/done/abort=%b, expected 000", {S_BUSY, S_FRAME_DONE, S_ABORT}); end
    checks++; if ({S_TX_FULL, S_RX_EMPTY} !== 2'b01) begin errors++; $display("[TB] FAIL reset_fifo: got full/empty=%b, expected 01", {S_TX_FULL, S_RX_EMPTY}); end
    S_RESET = 1'b0;
    tick(1);
  endtask

  task automatic test_basic_frame();
    logic [CW-1:0] exp_rx [3] = '{16'hA511, 16'hA522, 16'hA533};
    int  g0 = go_rises, d0 = done_cycles, v0 = cs_viol;
    bit  to;
    push_tx(16'h0011); push_tx(16'h0022); push_tx(16'h0033);
    start_frame(8'd3);
    checks++; if (S_SPI_CS_N !== 1'b0 || S_BUSY !== 1'b1) begin errors++; $display("[TB] FAIL basic_start: got cs_n=%b busy=%b, expected 0 1", S_SPI_CS_N, S_BUSY); end
    wait_idle(to);
    checks++; if (to) begin errors++; $display("[TB] FAIL basic_timeout: busy still 1, expected 0"); end
    checks++; if (go_rises - g0 != 3) begin errors++; $display("[TB] FAIL basic_go_count: got %0d, expected 3", go_rises - g0); end
    checks++; if (done_cycles - d0 != 1) begin errors++; $display("[TB] FAIL basic_done_pulse: got %0d cycles, expected 1", done_cycles - d0); end
    checks++; if (cs_viol != v0) begin errors++; $display("[TB] FAIL basic_cs_low: got %0d GO cycles with CS high, expected 0", cs_viol - v0); end
    checks++; if (S_SPI_CS_N !== 1'b1) begin errors++; $display("[TB] FAIL basic_cs_end: got %b, expected 1", S_SPI_CS_N); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (S_RX_EMPTY !== 1'b0 || S_RX_DATA !== exp_rx[i]) begin
        errors++; $display("[TB] FAIL basic_rx[%0d]: got %h empty=%b, expected %h", i, S_RX_DATA, S_RX_EMPTY, exp_rx[i]);
      end
      pop_rx();
    end
    checks++; if (S_RX_EMPTY !== 1'b1) begin errors++; $display("[TB] FAIL basic_rx_empty: got %b, expected 1", S_RX_EMPTY); end
  endtask

  task automatic test_tx_stall();
    int g0 = go_rises, d0 = done_cycles;
    bit to;
    start_frame(8'd2);
    tick(10);
    checks++; if ({S_BUSY, S_SPI_CS_N, M_CHAR_GO} !== 3'b100) begin errors++; $display("[TB] FAIL stall_state: got busy/cs_n/go=%b, expected 100", {S_BUSY, S_SPI_CS_N, M_CHAR_GO}); end
    checks++; if (go_rises != g0) begin errors++; $display("[TB] FAIL stall_no_go: got %0d GO, expected 0", go_rises - g0); end
    start_frame(8'd5);
    push_tx(16'h00A5);
    tick(20);
    checks++; if (go_rises - g0 != 1 || S_BUSY !== 1'b1) begin errors++; $display("[TB] FAIL stall_first: got go=%0d busy=%b, expected 1 1", go_rises - g0, S_BUSY); end
    checks++; if (S_RX_DATA !== 16'hA5A5) begin errors++; $display("[TB] FAIL stall_rx0: got %h, expected a5a5", S_RX_DATA); end
    push_tx(16'h005A);
    wait_idle(to);
    checks++; if (to || go_rises - g0 != 2 || done_cycles - d0 != 1) begin errors++; $display("[TB] FAIL stall_end: got timeout=%b go=%0d done=%0d, expected 0 2 1", to, go_rises - g0, done_cycles - d0); end
    pop_rx();
    checks++; if (S_RX_EMPTY !== 1'b0 || S_RX_DATA !== 16'hA55A) begin errors++; $display("[TB] FAIL stall_rx1: got %h empty=%b, expected a55a", S_RX_DATA, S_RX_EMPTY); end
    pop_rx();
  endtask

  task automatic test_rx_full();
    int g0;
    bit to;
    for (int i = 1; i <= 8; i++) push_tx(CW'(i));
    checks++; if (S_TX_FULL !== 1'b1) begin errors++; $display("[TB] FAIL txfull_flag: got %b, expected 1", S_TX_FULL); end
    push_tx(16'h00EE);
    start_frame(8'd8);
    wait_idle(to);
    checks++; if (to) begin errors++; $display("[TB] FAIL rxfull_fill: busy still 1, expected 0"); end
    push_tx(16'h0077);
    g0 = go_rises;
    start_frame(8'd1);
    tick(15);
    checks++; if (S_BUSY !== 1'b1 || go_rises != g0) begin errors++; $display("[TB] FAIL rxfull_stall: got busy=%b go=%0d, expected 1 0", S_BUSY, go_rises - g0); end
    checks++; if (S_RX_DATA !== 16'hA501) begin errors++; $display("[TB] FAIL rxfull_head: got %h, expected a501", S_RX_DATA); end
    pop_rx();
    wait_idle(to);
    checks++; if (to || go_rises - g0 != 1) begin errors++; $display("[TB] FAIL rxfull_issue: got timeout=%b go=%0d, expected 0 1", to, go_rises - g0); end
    for (int i = 2; i <= 9; i++) begin
      logic [CW-1:0] e;
      e = (i == 9) ? 16'hA577 : (16'hA500 | CW'(i));
      checks++;
      if (S_RX_EMPTY !== 1'b0 || S_RX_DATA !== e) begin
        errors++; $display("[TB] FAIL rxfull_rx[%0d]: got %h empty=%b, expected %h", i, S_RX_DATA, S_RX_EMPTY, e);
      end
      pop_rx();
    end
    checks++; if (S_RX_EMPTY !== 1'b1) begin errors++; $display("[TB] FAIL rxfull_drained: got %b, expected 1", S_RX_EMPTY); end
  endtask

  task automatic test_abort();
    int g0 = go_rises, d0, budget = 200;
    bit to;
    push_tx(16'h0041); push_tx(16'h0042); push_tx(16'h0043); push_tx(16'h0044);
    start_frame(8'd4);
    while (go_rises - g0 < 2 && budget > 0) begin tick(1); budget--; end
    checks++; if (go_rises - g0 != 2 || M_CHAR_GO !== 1'b1) begin errors++; $display("[TB] FAIL abort_reach: got go=%0d, expected 2 with GO high", go_rises - g0); end
    d0 = done_cycles;
    S_ENABLE = 1'b0;
    tick(1);
    checks++; if ({S_SPI_CS_N, M_CHAR_GO, S_ABORT, S_BUSY} !== 4'b1010) begin errors++; $display("[TB] FAIL abort_state: got cs_n/go/abort/busy=%b, expected 1010", {S_SPI_CS_N, M_CHAR_GO, S_ABORT, S_BUSY}); end
    tick(10);
    checks++; if (done_cycles != d0) begin errors++; $display("[TB] FAIL abort_no_done: got %0d pulses, expected 0", done_cycles - d0); end
    S_ENABLE = 1'b1;
    checks++; if (S_RX_EMPTY !== 1'b0 || S_RX_DATA !== 16'hA541) begin errors++; $display("[TB] FAIL abort_rx: got %h empty=%b, expected a541", S_RX_DATA, S_RX_EMPTY); end
    pop_rx();
    checks++; if (S_RX_EMPTY !== 1'b1) begin errors++; $display("[TB] FAIL abort_discard: got empty=%b, expected 1", S_RX_EMPTY); end
    start_frame(8'd2);
    checks++; if (S_ABORT !== 1'b0) begin errors++; $display("[TB] FAIL abort_clear: got %b, expected 0", S_ABORT); end
    wait_idle(to);
    checks++; if (to || S_RX_DATA !== 16'hA543) begin errors++; $display("[TB] FAIL abort_resume0: got %h timeout=%b, expected a543", S_RX_DATA, to); end
    pop_rx();
    checks++; if (S_RX_DATA !== 16'hA544) begin errors++; $display("[TB] FAIL abort_resume1: got %h, expected a544", S_RX_DATA); end
    pop_rx();
  endtask

  task automatic test_cs_timing();
    int setup_cnt = 0, hold_cnt = 0, budget = 100;
    S_CS_SETUP = 4'd5; S_CS_HOLD = 4'd3;
    push_tx(16'h0099);
    start_frame(8'd1);
    while (!M_CHAR_GO && budget > 0) begin
      if (!S_SPI_CS_N) setup_cnt++;
      tick(1); budget--;
    end
    checks++; if (setup_cnt != EXP_SETUP) begin errors++; $display("[TB] FAIL cs_setup: got %0d cycles, expected %0d", setup_cnt, EXP_SETUP); end
    budget = 100;
    while (!M_CHAR_DONE && budget > 0) begin tick(1); budget--; end
    tick(1);
    budget = 100;
    while (!S_SPI_CS_N && budget > 0) begin hold_cnt++; tick(1); budget--; end
    checks++; if (hold_cnt != EXP_HOLD) begin errors++; $display("[TB] FAIL cs_hold: got %0d cycles, expected %0d", hold_cnt, EXP_HOLD); end
    checks++; if (S_FRAME_DONE !== 1'b1) begin errors++; $display("[TB] FAIL cs_done: got %b, expected 1", S_FRAME_DONE); end
    checks++; if (S_RX_DATA !== 16'hA599) begin errors++; $display("[TB] FAIL cs_rx: got %h, expected a599", S_RX_DATA); end
    pop_rx();
    S_CS_SETUP = '0; S_CS_HOLD = '0;
    tick(2);
  endtask

  task automatic test_reset_midframe();
    int g0 = go_rises, budget = 100;
    push_tx(16'h0010); push_tx(16'h0020);
    start_frame(8'd2);
    while (go_rises == g0 && budget > 0) begin tick(1); budget--; end
    S_RESET = 1'b1;
    tick(1);
    checks++; if ({S_SPI_CS_N, M_CHAR_GO, S_BUSY, S_ABORT, S_FRAME_DONE} !== 5'b10000) begin errors++; $display("[TB] FAIL midreset_ctrl: got cs_n/go/busy/abort/done=%b, expected 10000", {S_SPI_CS_N, M_CHAR_GO, S_BUSY, S_ABORT, S_FRAME_DONE}); end
    checks++; if (M_WCHAR !== 16'h0000 || S_RX_EMPTY !== 1'b1 || S_TX_FULL !== 1'b0) begin errors++; $display("[TB] FAIL midreset_data: got wchar=%h rx_empty=%b tx_full=%b, expected 0000 1 0", M_WCHAR, S_RX_EMPTY, S_TX_FULL); end
    S_RESET = 1'b0;
    tick(1);
    start_frame(8'd0);
    checks++; if ({S_FRAME_DONE, S_SPI_CS_N, S_BUSY} !== 3'b110) begin errors++; $display("[TB] FAIL len0_done: got done/cs_n/busy=%b, expected 110", {S_FRAME_DONE, S_SPI_CS_N, S_BUSY}); end
    tick(1);
    checks++; if (S_FRAME_DONE !== 1'b0 || S_SPI_CS_N !== 1'b1) begin errors++; $display("[TB] FAIL len0_pulse: got done=%b cs_n=%b, expected 0 1", S_FRAME_DONE, S_SPI_CS_N); end
    g0 = go_rises;
    start_frame(8'd1);
    tick(10);
    checks++; if (go_rises != g0 || S_BUSY !== 1'b1) begin errors++; $display("[TB] FAIL midreset_txflush: got go=%0d busy=%b, expected 0 1", go_rises - g0, S_BUSY); end
    S_ENABLE = 1'b0;
    tick(1);
    S_ENABLE = 1'b1;
    checks++; if (S_ABORT !== 1'b1 || S_BUSY !== 1'b0) begin errors++; $display("[TB] FAIL midreset_abort: got abort=%b busy=%b, expected 1 0", S_ABORT, S_BUSY); end
  endtask

  initial begin
    S_RESET = 1'b1; S_ENABLE = 1'b1; S_FRAME_GO = 1'b0; S_FRAME_LEN = '0;
    S_CS_SETUP = '0; S_CS_HOLD = '0; S_TX_WR = 1'b0; S_TX_DATA = '0; S_RX_RD = 1'b0;
    test_reset();
    test_basic_frame();
    test_tx_stall();
    test_rx_full();
    test_abort();
    test_cs_timing();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
